apb_bank_arbiter: RTL and testbench

Two-master APB arbiter for the GPIO expander bank bus. It shares the APB bus to the BANK_NUM GPIO banks between the SPI-to-APB bridge (master 0) and a second on-chip requester (master 1, e.g. an interrupt/status poller). Each transfer is granted round-robin, then run as a standard APB SETUP/ACCESS sequence with a wait-state timeout. The response is returned only to the granted master.

---
 rtl/spi_gpio_pkg.sv | 31 +++
 rtl/apb_bank_arbiter_rr_arb2.sv | 20 ++
 rtl/apb_bank_arbiter.sv | 179 +++++++++++++++++
 tb/tb_apb_bank_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_gpio_pkg.sv
// Shared state encoding, grant constants and default widths for the GPIO expander bank bus.
package spi_gpio_pkg;

  localparam int BANK_NUM   = 2;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // On contention the master that did not win last time goes first.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    if (req == 2'b11) begin
      pick = ~last_grant;
    end else if (req[1]) begin
      pick = GRANT_M1;
    end else begin
      pick = GRANT_M0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_bank_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the decision is combinational so a request seen in IDLE is granted that cycle.
module rr_arb2
  import spi_gpio_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  // clk/resetn are kept on the port list so a registered arbiter can drop in later.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ resetn;

  assign gnt_valid = |req;
  assign gnt_idx   = rr_pick(req, last_grant);

endmodule

// File: rtl/apb_bank_arbiter.sv
// Two-master round-robin APB arbiter for the GPIO expander bank bus, with a wait-state timeout.
// IDLE|arbitrate and latch  SETUP|psel, no enable  ACCESS|penable, wait or time out  ERR|multi-hot psel, error reply
module apb_bank_arbiter #(
  parameter int BANK_NUM   = spi_gpio_pkg::BANK_NUM,
  parameter int DATA_WIDTH = spi_gpio_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = spi_gpio_pkg::ADDR_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [BANK_NUM-1:0]   m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pwdata,
  output logic                  m0_pready,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pslverr,
  input  logic [BANK_NUM-1:0]   m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pwdata,
  output logic                  m1_pready,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pslverr,
  output logic [BANK_NUM-1:0]   b_psel,
  output logic                  b_penable,
  output logic                  b_pwrite,
  output logic [ADDR_WIDTH-1:0] b_paddr,
  output logic [DATA_WIDTH-1:0] b_pwdata,
  input  logic [DATA_WIDTH-1:0] b_prdata,
  input  logic                  b_pready,
  output logic                  grant,
  output logic                  busy
);
  import spi_gpio_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  last_grant_q;
  logic                  grant_q;
  logic                  busy_q;
  logic [BANK_NUM-1:0]   b_psel_q;
  logic                  b_penable_q;
  logic                  b_pwrite_q;
  logic [ADDR_WIDTH-1:0] b_paddr_q;
  logic [DATA_WIDTH-1:0] b_pwdata_q;

  logic [1:0]            req;
  logic                  gnt_idx;
  logic                  gnt_valid;
  logic [BANK_NUM-1:0]   sel_psel;
  logic                  sel_pwrite;
  logic [ADDR_WIDTH-1:0] sel_paddr;
  logic [DATA_WIDTH-1:0] sel_pwdata;
  logic                  timeout_hit;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;

  // penable from the masters carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign req = {|m1_psel, |m0_psel};

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  assign sel_psel    = (gnt_idx == GRANT_M1) ? m1_psel   : m0_psel;
  assign sel_pwrite  = (gnt_idx == GRANT_M1) ? m1_pwrite : m0_pwrite;
  assign sel_paddr   = (gnt_idx == GRANT_M1) ? m1_paddr  : m0_paddr;
  assign sel_pwdata  = (gnt_idx == GRANT_M1) ? m1_pwdata : m0_pwdata;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_M1;
      grant_q      <= GRANT_M0;
      busy_q       <= 1'b0;
      b_psel_q     <= '0;
      b_penable_q  <= 1'b0;
      b_pwrite_q   <= 1'b0;
      b_paddr_q    <= '0;
      b_pwdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            busy_q       <= 1'b1;
            if ($onehot(sel_psel)) begin
              state_q    <= ST_SETUP;
              b_psel_q   <= sel_psel;
              b_pwrite_q <= sel_pwrite;
              b_paddr_q  <= sel_paddr;
              b_pwdata_q <= sel_pwdata;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end
        ST_SETUP: begin
          state_q     <= ST_ACCESS;
          b_penable_q <= 1'b1;
          cnt_q       <= '0;
        end
        ST_ACCESS: begin
          if (b_pready || timeout_hit) begin
            state_q     <= ST_IDLE;
            b_psel_q    <= '0;
            b_penable_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Slave ready wins over the timeout when both land in the same cycle.
  always_comb begin
    done  = 1'b0;
    err   = 1'b0;
    rdata = '0;
    case (state_q)
      ST_ACCESS: begin
        if (b_pready) begin
          done  = 1'b1;
          rdata = b_pwrite_q ? '0 : b_prdata;
        end else if (timeout_hit) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      ST_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign m0_pready  = done && (grant_q == GRANT_M0);
  assign m0_pslverr = err  && (grant_q == GRANT_M0);
  assign m0_prdata  = (grant_q == GRANT_M0) ? rdata : '0;
  assign m1_pready  = done && (grant_q == GRANT_M1);
  assign m1_pslverr = err  && (grant_q == GRANT_M1);
  assign m1_prdata  = (grant_q == GRANT_M1) ? rdata : '0;

  assign b_psel    = b_psel_q;
  assign b_penable = b_penable_q;
  assign b_pwrite  = b_pwrite_q;
  assign b_paddr   = b_paddr_q;
  assign b_pwdata  = b_pwdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_apb_bank_arbiter.sv
// Scoreboard bench for apb_bank_arbiter: two random masters, a behavioural bank responder, and a round-robin model.
module tb_apb_bank_arbiter;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic [1:0] psel;
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         wt;
  } txn_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] m0_psel, m1_psel;
  logic       m0_penable, m1_penable, m0_pwrite, m1_pwrite;
  logic [2:0] m0_paddr, m1_paddr;
  logic [7:0] m0_pwdata, m1_pwdata;
  logic       m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic [7:0] m0_prdata, m1_prdata;
  logic [1:0] b_psel;
  logic       b_penable, b_pwrite;
  logic [2:0] b_paddr;
  logic [7:0] b_pwdata;
  logic [7:0] b_prdata;
  logic       b_pready;
  logic       grant, busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  txn_t cur_txn[2];
  bit   grant_seen[2];
  int   done_cnt[2];
  int   owner;
  bit   last_g;

  always #5 clk = ~clk;

  apb_bank_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
    .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
    .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite),
    .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_prdata(b_prdata),
    .b_pready(b_pready), .grant(grant), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected upstream response from the transfer rules alone.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    if (t.psel == 2'b11) begin
      e.err = 1'b1; e.rdata = 8'h00; e.lat = 1;
    end else if (t.wt >= TIMEOUT) begin
      e.err = 1'b1; e.rdata = 8'h00; e.lat = 2 + TIMEOUT - 1;
    end else begin
      e.err = 1'b0; e.rdata = t.write ? 8'h00 : t.rdata; e.lat = 2 + t.wt;
    end
    return e;
  endfunction

  function automatic txn_t mk(input logic [1:0] ps, input logic wr, input logic [2:0] a,
                              input logic [7:0] wd, input logic [7:0] rd, input int wt);
    txn_t t;
    t.psel = ps; t.write = wr; t.addr = a; t.wdata = wd; t.rdata = rd; t.wt = wt;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   r;
    r = int'($urandom_range(0, 7));
    t.psel  = (r == 0) ? 2'b11 : ((r < 4) ? 2'b01 : 2'b10);
    t.write = 1'($urandom_range(0, 1));
    t.addr  = 3'($urandom);
    t.wdata = 8'($urandom);
    t.rdata = 8'($urandom);
    case ($urandom_range(0, 5))
      0:       t.wt = 0;
      1:       t.wt = 1;
      2:       t.wt = int'($urandom_range(2, 6));
      3:       t.wt = int'($urandom_range(TIMEOUT - 2, TIMEOUT - 1));
      4:       t.wt = int'($urandom_range(TIMEOUT, TIMEOUT + 4));
      default: t.wt = int'($urandom_range(0, 3));
    endcase
    return t;
  endfunction

  task automatic drive(input int m, input logic [1:0] ps, input logic en, input logic wr,
                       input logic [2:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_psel = ps; m0_penable = en; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d;
    end else begin
      m1_psel = ps; m1_penable = en; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d;
    end
  endtask

  task automatic do_txn(input int m, input txn_t t, input bit drop);
    int   start;
    int   budget;
    exp_t e;
    e = model(t);
    if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    cur_txn[m]    = t;
    grant_seen[m] = 1'b0;
    start         = done_cnt[m];
    drive(m, t.psel, 1'b1, t.write, t.addr, t.wdata);
    budget = 300;
    while (done_cnt[m] == start && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (drop && grant_seen[m]) drive(m, 2'b00, 1'b0, t.write, ~t.addr, ~t.wdata);
    end
    check($sformatf("txn_done_m%0d", m), 64'(budget > 0), 64'(1));
    drive(m, 2'b00, 1'b0, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic master(input int m, input int n);
    int gap;
    if (m == 0) begin
      do_txn(0, mk(2'b01, 1'b1, 3'd3, 8'hA5, 8'h00, 0), 1'b0);
      do_txn(0, mk(2'b10, 1'b0, 3'd1, 8'h00, 8'h5A, 5), 1'b0);
      do_txn(0, mk(2'b01, 1'b0, 3'd6, 8'h00, 8'hFF, TIMEOUT + 24), 1'b0);
      do_txn(0, mk(2'b10, 1'b0, 3'd4, 8'h11, 8'h6B, TIMEOUT - 1), 1'b0);
    end else begin
      do_txn(1, mk(2'b10, 1'b0, 3'd2, 8'h00, 8'h3C, 0), 1'b0);
      do_txn(1, mk(2'b11, 1'b1, 3'd7, 8'h42, 8'h99, 0), 1'b0);
      do_txn(1, mk(2'b01, 1'b0, 3'd5, 8'h00, 8'h96, TIMEOUT - 2), 1'b1);
    end
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      do_txn(m, rand_txn(), ($urandom_range(0, 4) == 0));
    end
  endtask

  // Bank responder: drops ready in after the scheduled number of wait states.
  initial begin : responder
    int   acc;
    txn_t t;
    acc = -1;
    b_pready = 1'b0;
    b_prdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        acc = -1; b_pready = 1'b0; b_prdata = 8'h00;
      end else begin
        t = cur_txn[owner];
        if (b_penable) begin
          acc++;
          b_pready = (acc == t.wt);
          b_prdata = b_pready ? t.rdata : 8'($urandom);
        end else begin
          acc = -1;
          b_pready = ($urandom_range(0, 3) == 0);
          b_prdata = 8'($urandom);
        end
      end
    end
  end

  // Monitor: round-robin prediction, bus checks, and scoreboard pops on upstream ready.
  initial begin : monitor
    bit   active;
    int   since;
    bit   r0, r1, pred, multi, got_err;
    logic [7:0] got_rd, oth_rd;
    logic oth_err;
    exp_t e;
    txn_t t;
    active = 1'b0; since = 0; last_g = 1'b1; owner = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        active = 1'b0;
        last_g = 1'b1;
      end else if (active) begin
        since++;
        t     = cur_txn[owner];
        multi = (t.psel == 2'b11);
        if (since == 1) begin
          check("grant_idx", 64'(grant), 64'(owner));
          check("busy_set", 64'(busy), 64'(1));
          if (multi) check("err_no_bus", 64'({b_psel, b_penable}), 64'(0));
          else check("setup_bus", 64'({b_psel, b_penable, b_pwrite, b_paddr, b_pwdata}),
                     64'({t.psel, 1'b0, t.write, t.addr, t.wdata}));
        end else if (!multi) begin
          check("access_bus", 64'({busy, b_psel, b_penable}), 64'({1'b1, t.psel, 1'b1}));
        end
        if (m0_pready || m1_pready) begin
          check("resp_master", 64'({m1_pready, m0_pready}), (owner == 1) ? 64'(2'b10) : 64'(2'b01));
          got_rd  = (owner == 1) ? m1_prdata  : m0_prdata;
          got_err = (owner == 1) ? m1_pslverr : m0_pslverr;
          oth_rd  = (owner == 1) ? m0_prdata  : m1_prdata;
          oth_err = (owner == 1) ? m0_pslverr : m1_pslverr;
          check("other_quiet", 64'({oth_rd, oth_err}), 64'(0));
          if ((owner == 1) ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
            check("resp_unexpected", 64'(1), 64'(0));
          end else begin
            e = (owner == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
            check("resp_rdata", 64'(got_rd), 64'(e.rdata));
            check("resp_err", 64'(got_err), 64'(e.err));
            check("resp_latency", 64'(since), 64'(e.lat));
          end
          done_cnt[owner]++;
          active = 1'b0;
        end else if (since > TIMEOUT + 4) begin
          check("resp_missing", 64'(since), 64'(e.lat));
          active = 1'b0;
        end
      end else begin
        check("idle_quiet", 64'({busy, b_psel, b_penable, m0_pready, m1_pready, m0_pslverr, m1_pslverr}), 64'(0));
        r0 = |m0_psel;
        r1 = |m1_psel;
        if (r0 || r1) begin
          pred   = (r0 && r1) ? ~last_g : r1;
          last_g = pred;
          owner  = int'(pred);
          grant_seen[owner] = 1'b1;
          active = 1'b1;
          since  = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int budget;
    resetn = 1'b0;
    drive(0, 2'b00, 1'b0, 1'b0, 3'd0, 8'd0);
    drive(1, 2'b00, 1'b0, 1'b0, 3'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus", 64'({b_psel, b_penable, b_pwrite, b_paddr, b_pwdata}), 64'(0));
    check("reset_ctrl", 64'({grant, busy}), 64'(0));
    check("reset_up", 64'({m0_pready, m1_pready, m0_pslverr, m1_pslverr, m0_prdata, m1_prdata}), 64'(0));
    resetn = 1'b1;

    fork
      master(0, 24);
      master(1, 24);
    join
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q0.size() + exp_q1.size()), 64'(0));

    // Reset in the middle of an ACCESS phase loses the transfer.
    cur_txn[1] = mk(2'b10, 1'b0, 3'd5, 8'h00, 8'h77, 100);
    drive(1, 2'b10, 1'b1, 1'b0, 3'd5, 8'h00);
    budget = 50;
    while (!b_penable && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("rst_reach_access", 64'(b_penable), 64'(1));
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_bus", 64'({b_psel, b_penable, b_pwrite, b_paddr, b_pwdata}), 64'(0));
    check("rst_ctrl", 64'({grant, busy}), 64'(0));
    check("rst_up", 64'({m0_pready, m1_pready, m0_pslverr, m1_pslverr, m0_prdata, m1_prdata}), 64'(0));
    drive(1, 2'b00, 1'b0, 1'b0, 3'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_txn(1, mk(2'b01, 1'b0, 3'd2, 8'h00, 8'hC3, 2), 1'b0);
    fork
      do_txn(0, mk(2'b10, 1'b1, 3'd1, 8'h5F, 8'h00, 1), 1'b0);
      do_txn(1, mk(2'b01, 1'b0, 3'd0, 8'h00, 8'h81, 0), 1'b0);
    join
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained_end", 64'(exp_q0.size() + exp_q1.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
